// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer: posted-write store buffer between the CPU data-memory
// port and a single-port data RAM.
//
// Stores are queued in a small circular FIFO. They drain to RAM in any cycle
// in which the port is not needed by a load. Loads complete combinationally
// in the same cycle they are presented.
//
// Build option: define WBUF_FWD_EN to forward data from the youngest matching
// pending store to the load. A forwarded load never stalls.
// Without WBUF_FWD_EN, a load that matches a pending store stalls. The buffer
// then drains until no match remains, and the load completes from RAM.
module dmem_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_waddr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_re,
  input  logic [AW-1:0] cpu_raddr,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  output logic          ram_re,
  input  logic [DW-1:0] ram_rdata,
  output logic          buf_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Entry storage. Contents are only meaningful between rd_ptr and count,
  // so the array itself carries no reset.
  logic [AW-1:0] entry_addr [DEPTH];
  logic [DW-1:0] entry_data [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          buf_full;
  logic          match_hit;
  logic [PW-1:0] scan_idx;
`ifdef WBUF_FWD_EN
  logic [DW-1:0] match_data;
`endif
  logic          load_ram;
  logic          load_stall;
  logic          store_stall;
  logic          drain;
  logic          enq;

  assign buf_full  = (count == FULL_COUNT);
  assign buf_empty = (count == '0);

  // Scan the valid entries from oldest to youngest. A later hit overwrites
  // an earlier one, so the surviving match is the youngest pending store.
  always_comb begin
    match_hit  = 1'b0;
    scan_idx   = '0;
`ifdef WBUF_FWD_EN
    match_data = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = rd_ptr + PW'(k);
      if ((CW'(k) < count) && (entry_addr[scan_idx] == cpu_raddr)) begin
        match_hit  = 1'b1;
`ifdef WBUF_FWD_EN
        match_data = entry_data[scan_idx];
`endif
      end
    end
  end

  // A load uses the RAM port only when no pending store holds its address.
  // Without forwarding, such a load must wait for the matching stores to drain.
  // Everything is gated by rst so the RAM is quiet while reset is held.
`ifdef WBUF_FWD_EN
  assign load_stall = 1'b0;
`else
  assign load_stall = rst && cpu_re && match_hit;
`endif
  assign load_ram    = rst && cpu_re && !match_hit;
  assign store_stall = rst && cpu_we && buf_full;
  assign cpu_stall   = store_stall || load_stall;
  assign drain       = rst && !load_ram && !buf_empty;
  assign enq         = rst && cpu_we && !cpu_stall;

  // RAM port arbitration: a RAM load has priority, then a head-of-queue drain.
  // Otherwise the port is idle with all outputs at zero.
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    if (load_ram) begin
      ram_re   = 1'b1;
      ram_addr = cpu_raddr;
    end else if (drain) begin
      ram_we    = 1'b1;
      ram_addr  = entry_addr[rd_ptr];
      ram_wdata = entry_data[rd_ptr];
    end
  end

  // Load data: forwarded store data, RAM data, or zero when no load completes.
  always_comb begin
    cpu_rdata = '0;
`ifdef WBUF_FWD_EN
    if (rst && cpu_re && match_hit) begin
      cpu_rdata = match_data;
    end else if (load_ram) begin
      cpu_rdata = ram_rdata;
    end
`else
    if (load_ram) begin
      cpu_rdata = ram_rdata;
    end
`endif
  end

  // Capture an accepted store into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (enq) begin
      entry_addr[wr_ptr] <= cpu_waddr;
      entry_data[wr_ptr] <= cpu_wdata;
    end
  end

  // Pointer and occupancy bookkeeping. Pointers wrap naturally because DEPTH
  // is a power of two. A simultaneous enqueue and drain leaves count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (drain) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({enq, drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/dmem_write_buffer.md
# dmem_write_buffer

Posted-write store buffer between the pipeline processor's data-memory port and the single-port data RAM. Stores are queued in a small FIFO and drained to RAM in cycles the CPU is not reading. Loads are served from the youngest matching pending store when forwarding is compiled in, otherwise from RAM. The buffer raises a stall to the processor when it cannot accept a store or cannot yet service a load.

## Interface
- DEPTH, 4, number of store entries; power of two, 2..16
- AW, 32, address width
- DW, 32, data width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_we  in  1  store request (write_dmem)
- cpu_waddr  in  AW  store address
- cpu_wdata  in  DW  store data
- cpu_re  in  1  load request (read_dmem)
- cpu_raddr  in  AW  load address
- cpu_rdata  out  DW  load data, combinational
- cpu_stall  out  1  processor must hold current MEM-stage request
- ram_addr  out  AW  RAM address, shared by read and drain
- ram_wdata  out  DW  RAM write data
- ram_we  out  1  RAM write strobe
- ram_re  out  1  RAM read strobe
- ram_rdata  in  DW  RAM read data, combinational
- buf_empty  out  1  no pending stores

## Operation
- Storage: circular FIFO, DEPTH entries of {addr, data}; wr_ptr, rd_ptr (log2 DEPTH bits, wrap), count (log2 DEPTH + 1 bits, 0..DEPTH).
- Enqueue: cpu_we && !cpu_stall → entry written at wr_ptr on clk rise; wr_ptr++, count++.
- Port arbitration per cycle, priority order:
  1. Load needing RAM (cpu_re, no forward hit, no hazard stall): ram_re=1, ram_addr=cpu_raddr, cpu_rdata=ram_rdata, ram_we=0.
  2. Otherwise, if count>0: drain head: ram_we=1, ram_addr=addr[rd_ptr], ram_wdata=data[rd_ptr]; rd_ptr++, count-- on clk rise.
  3. Otherwise idle: ram_we=0, ram_re=0, ram_addr=0.
- Forwarding (FWD_EN): load address compared against all valid entries (full AW compare); youngest match (closest to wr_ptr) supplies cpu_rdata; RAM port is then free for a drain the same cycle.
- Simultaneous enqueue + drain: count unchanged, both pointers advance.
- Store and load in same cycle, same address: load sees pre-store state; new store visible from next cycle.
- Duplicate store addresses allowed; drained in order, last one wins in RAM.
- cpu_stall = (cpu_we && count==DEPTH) || load hazard stall (see Configuration). A stalled store is not enqueued; the processor re-presents it.
- cpu_rdata = 0 when cpu_re=0.
- buf_empty = (count==0).

## Timing
- Reset (rst low, async): pointers and count cleared, pending entries discarded; outputs during reset: cpu_stall=0, ram_we=0, ram_re=0, ram_addr=0, ram_wdata=0, cpu_rdata=0, buf_empty=1. Entry array need not be cleared.
- Reset released mid-drain: lost stores are not written; RAM is not touched after rst asserts.
- Load latency: 0 cycles (combinational, same cycle as cpu_re), forwarded or not.
- Store acceptance: 1 cycle to enqueue; earliest RAM write on the cycle after enqueue if the port is free.
- Drain throughput: 1 entry per non-load cycle.
- Full: with count==DEPTH and a pending store, cpu_stall=1 that cycle even if a drain occurs; the store is accepted next cycle.
- cpu_stall is combinational from count, cpu_we, cpu_re, and match logic; there is no registered stall.

## Configuration
- WBUF_FWD_EN defined: store-to-load forwarding as above; loads never stall.
- WBUF_FWD_EN undefined: no forward path. A load whose address matches any pending entry raises cpu_stall and does not use RAM; the port drains instead, and the load completes from RAM once no match remains. A non-matching load proceeds from RAM with no stall.

## Test plan
- Reset: drive rst=0 mid-stream with 3 entries queued → buf_empty=1, ram_we=0 immediately; no further RAM writes after release.
- Single store: sw 0x000D0000 to addr 12, no loads → ram_we=1 with ram_addr=12, ram_wdata=0x000D0000 exactly one cycle after enqueue; buf_empty=1 after that.
- Fill: DEPTH+1 back-to-back stores while cpu_re is held high to a non-matching address → cpu_stall=1 only on the 5th store while count==4; all 5 stores reach RAM in order once loads stop.
- Forward (FWD_EN): store 0x00120000 to addr 12, then store 0x00000005 to addr 12, then load addr 12 while both are pending → cpu_rdata=0x00000005, no stall, and a drain occurs the same cycle.
- No forward (undefined): same sequence → cpu_stall=1 for two drain cycles; the load then returns 0x00000005 from RAM.
- Same-cycle store/load to addr 12 with RAM holding 0x00120000 → cpu_rdata=0x00120000; a load on the next cycle returns the new value.
